// File: rtl/div_rem_unit_pkg.sv
// Shared CPU definitions: decoded instruction indices, divider FSM states and
// small helpers used by the control unit and the divide/remainder unit.
package div_rem_unit_pkg;

    localparam int DATA_W = 32;

    localparam logic [31:0] OP_DIV      = 32'd14;
    localparam logic [31:0] OP_DIVU     = 32'd15;
    localparam logic [31:0] OP_REM      = 32'd16;
    localparam logic [31:0] OP_REMU     = 32'd17;
    localparam logic [31:0] OP_LS_FIRST = 32'd27;
    localparam logic [31:0] OP_LS_LAST  = 32'd34;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_div_rem(input logic [31:0] idx);
        return (idx >= OP_DIV) && (idx <= OP_REMU);
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_rem_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the
// divisor and keep the difference when it does not go negative.
module div_rem_step
    import div_rem_unit_pkg::*;
(
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);

    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              borrow;
    logic              unused_diff_msb;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        shifted  = {rem, quo[DATA_W-1]};
        {borrow, diff} = {1'b0, shifted} - {2'b00, divisor};
        rem_next = shifted[DATA_W-1:0];
        quo_next = {quo[DATA_W-2:0], 1'b0};
        if (!borrow) begin
            // A successful subtract leaves less than the divisor, so the MSB is always zero.
            rem_next = diff[DATA_W-1:0];
            quo_next = {quo[DATA_W-2:0], 1'b1};
        end
    end

    assign unused_diff_msb = diff[DATA_W];

endmodule

// File: rtl/div_rem_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one restoring step per clock, with
// divide-by-zero and signed overflow resolved at accept time.
module div_rem_unit
    import div_rem_unit_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [31:0]       i_instruction,
    input  logic [DATA_W-1:0] i_rs1,
    input  logic [DATA_W-1:0] i_rs2,
    output logic [DATA_W-1:0] o_result,
    output logic              o_finished,
    output logic              o_busy
);

    state_t            state;
    logic [4:0]        count;
    logic              armed;
    logic              is_rem;
    logic              neg_q;
    logic              neg_r;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] divisor;
    logic [DATA_W-1:0] rem_nx;
    logic [DATA_W-1:0] quo_nx;

    logic              op_signed;
    logic              op_rem;
    logic              div_zero;
    logic              overflow;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W-1:0] special_res;
    logic [DATA_W-1:0] final_res;

    div_rem_step u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    always_comb begin
        op_signed   = (i_instruction == OP_DIV) || (i_instruction == OP_REM);
        op_rem      = (i_instruction == OP_REM) || (i_instruction == OP_REMU);
        mag_a       = apply_sign(op_signed && i_rs1[DATA_W-1], i_rs1);
        mag_b       = apply_sign(op_signed && i_rs2[DATA_W-1], i_rs2);
        div_zero    = (i_rs2 == '0);
        overflow    = op_signed && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);
        // Divide-by-zero returns the raw dividend as remainder; overflow leaves remainder 0.
        special_res = div_zero ? (op_rem ? i_rs1 : '1) : (op_rem ? '0 : 32'h8000_0000);
        final_res   = is_rem ? apply_sign(neg_r, rem_nx) : apply_sign(neg_q, quo_nx);
    end

    // NOTE: all state here is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            count      <= '0;
            armed      <= 1'b1;
            is_rem     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
            o_result   <= '0;
            o_finished <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!i_start) begin
                        armed <= 1'b1;
                    end else if (armed && is_div_rem(i_instruction)) begin
                        is_rem  <= op_rem;
                        neg_q   <= op_signed && (i_rs1[DATA_W-1] ^ i_rs2[DATA_W-1]);
                        neg_r   <= op_signed && i_rs1[DATA_W-1];
                        rem     <= '0;
                        quo     <= mag_a;
                        divisor <= mag_b;
                        count   <= '0;
                        o_busy  <= 1'b1;
                        if (div_zero || overflow) begin
                            o_result   <= special_res;
                            o_finished <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!i_start) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        armed  <= 1'b1;
                    end else begin
                        rem   <= rem_nx;
                        quo   <= quo_nx;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            o_result   <= final_res;
                            o_finished <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Stay disarmed until the control unit leaves EXECUTE.
                    o_finished <= 1'b0;
                    o_busy     <= 1'b0;
                    armed      <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_rem_unit.sv
// Scoreboard bench for div_rem_unit: expected results and completion cycles are
// queued at issue time and matched by a monitor on every o_finished pulse.
module tb_div_rem_unit;
    import div_rem_unit_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [31:0] i_instruction;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic [31:0] o_result;
    logic        o_finished;
    logic        o_busy;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    div_rem_unit dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_instruction (i_instruction),
        .i_rs1         (i_rs1),
        .i_rs2         (i_rs2),
        .o_result      (o_result),
        .o_finished    (o_finished),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_signed_op(input logic [31:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // RISC-V M semantics by plain 64-bit arithmetic (truncating division).
    function automatic logic [31:0] model(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_v, q, r;
        bit     want_q;
        want_q = (op == OP_DIV) || (op == OP_DIVU);
        if (b == 32'd0) return want_q ? 32'hFFFF_FFFF : a;
        if (is_signed_op(op)) begin
            sa   = longint'($signed(a));
            sb_v = longint'($signed(b));
        end else begin
            sa   = longint'(a);
            sb_v = longint'(b);
        end
        q = sa / sb_v;
        r = sa % sb_v;
        return want_q ? q[31:0] : r[31:0];
    endfunction

    function automatic int latency(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (is_signed_op(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic do_op(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold_extra, input bit scramble);
        bit seen;
        @(posedge i_clk); #1;
        i_start       = 1'b1;
        i_instruction = op;
        i_rs1         = a;
        i_rs2         = b;
        sb.push_back('{model(op, a, b), cyc + latency(op, a, b)});
        if (scramble) begin
            @(posedge i_clk); #1;
            i_rs1         = $urandom;
            i_rs2         = $urandom;
            i_instruction = OP_DIV + 32'($urandom_range(0, 3));
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge i_clk);
            if (o_finished) seen = 1'b1;
        end
        check("op_finished", 32'(seen), 32'd1);
        repeat (hold_extra) @(posedge i_clk);
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (o_finished) begin
                if (sb.size() == 0) begin
                    check("unexpected_finish", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", o_result, e.res);
                    check("finish_cycle", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int k;
        logic [31:0] op, a, b;

        i_rst = 1'b1; i_start = 1'b0; i_instruction = '0; i_rs1 = '0; i_rs2 = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_result", o_result, 32'd0);
        check("reset_finished", 32'(o_finished), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Directed cases
        do_op(OP_DIV, 32'd20, 32'hFFFF_FFFD, 0, 1'b1);
        @(negedge i_clk);
        check("c34_finished", 32'(o_finished), 32'd0);
        check("c34_busy", 32'(o_busy), 32'd0);
        do_op(OP_REM,  32'hFFFF_FFEC, 32'd3, 0, 1'b1);
        do_op(OP_REMU, 32'hFFFF_FFEC, 32'd3, 0, 1'b1);
        do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd2, 3, 1'b0);
        do_op(OP_DIV,  32'd1000, 32'd10, 0, 1'b0);
        do_op(OP_DIV,  32'd7, 32'd0, 0, 1'b1);
        do_op(OP_REMU, 32'd7, 32'd0, 0, 1'b1);
        do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
        do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);

        // Synchronous reset in the middle of a division
        @(posedge i_clk); #1;
        i_start = 1'b1; i_instruction = OP_DIV; i_rs1 = 32'd100; i_rs2 = 32'd7;
        k = cyc;
        repeat (10) @(posedge i_clk); #1;
        check("reset_case_c10", 32'(cyc - k), 32'd10);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_start = 1'b0;
        @(negedge i_clk);
        check("busy_after_reset", 32'(o_busy), 32'd0);
        do_op(OP_DIV, 32'd100, 32'd7, 0, 1'b0);

        // Non-divide index never starts the unit
        @(posedge i_clk); #1;
        i_start = 1'b1; i_instruction = OP_LS_FIRST; i_rs1 = 32'd9; i_rs2 = 32'd3;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            check("load_idle", {30'd0, o_busy, o_finished}, 32'd0);
        end
        @(posedge i_clk); #1;
        i_start = 1'b0;

        // Abort by dropping i_start in C5
        @(posedge i_clk); #1;
        i_start = 1'b1; i_instruction = OP_DIV; i_rs1 = 32'd100; i_rs2 = 32'd7;
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        check("busy_in_calc", 32'(o_busy), 32'd1);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        check("busy_after_abort", 32'(o_busy), 32'd0);
        repeat (40) @(negedge i_clk);

        // Randomised operations
        for (int n = 0; n < 60; n++) begin
            op = OP_DIV + 32'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 100));
                4: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(op, a, b, 0, 1'b1);
        end

        repeat (5) @(negedge i_clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
